spi_master_cfg: RTL and testbench

//  Parametrised SPI host: one frame of 1..DW bits per start, all four CPOL/CPHA modes,

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_clk_div.sv | 27 ++
 rtl/spi_master_cfg.sv | 149 ++++++++++++++
 tb/tb_spi_master_cfg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI host: FSM state encoding, SPI mode pair and
// the frame-bit-to-register-position mapping used on both the tx and rx sides.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Maps the n-th bit on the wire to its position in the right-aligned data word.
    function automatic int bit_pos(input logic lsb_first, input int len, input int idx);
        return lsb_first ? idx : (len - 1 - idx);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every div+1 cycles while en is high.
// No backpressure; the count restarts from zero whenever en drops.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// SPI host, one frame per accepted start; done/rx_valid pulse (2*len+2)*(div+1)+1 cycles
// after accept. Starts are only taken in IDLE or DONE; starts while busy are dropped.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DW     = 32,
    parameter int CS_NUM = 4,
    parameter int DIV_W  = 8,
    parameter int LEN_W  = $clog2(DW) + 1,
    parameter int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_start,
    input  logic              spi_cfg_cpol,
    input  logic              spi_cfg_cpha,
    input  logic              spi_cfg_lsb_first,
    input  logic [DIV_W-1:0]  spi_cfg_div,
    input  logic [LEN_W-1:0]  spi_cfg_len,
    input  logic [CS_W-1:0]   spi_cfg_cs,
    input  logic [DW-1:0]     spi_tx_data,
    output logic              spi_busy,
    output logic              spi_done,
    output logic [DW-1:0]     spi_rx_data,
    output logic              spi_rx_valid,
    output logic              spi_sck,
    output logic [CS_NUM-1:0] spi_csn,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    spi_state_t        state, state_nxt;
    spi_mode_t         mode_q;
    logic              lsb_q;
    logic [DIV_W-1:0]  div_q;
    logic [LEN_W-1:0]  len_q, len_eff;
    logic [DW-1:0]     tx_q, rx_sh;
    logic [LEN_W:0]    edge_q;
    logic [CS_NUM-1:0] csn_sel;
    logic              tick, div_en, accept, last_edge, edge_go;
    logic              samp, drv_ok, drv_bit, first_bit;
    int                bit_idx, drv_idx, rx_pos;

    assign accept    = spi_start && ((state == IDLE) || (state == DONE));
    assign div_en    = (state == SETUP) || (state == XFER) || (state == HOLD);
    assign last_edge = (edge_q == {len_q, 1'b0});
    assign edge_go   = tick && ((state == SETUP) || ((state == XFER) && !last_edge));
    assign len_eff   = ((spi_cfg_len == '0) || (spi_cfg_len > LEN_W'(DW))) ? LEN_W'(DW) : spi_cfg_len;

    spi_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = XFER;
            XFER:    if (tick && last_edge) state_nxt = HOLD;
            HOLD:    if (tick) state_nxt = DONE;
            DONE:    state_nxt = accept ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Even edges are leading edges; cpha picks which edge samples and which drives.
    always_comb begin
        bit_idx   = int'(edge_q >> 1);
        samp      = (edge_q[0] == mode_q.cpha);
        drv_idx   = mode_q.cpha ? bit_idx : (bit_idx + 1);
        drv_ok    = (drv_idx < int'(len_q));
        rx_pos    = bit_pos(lsb_q, int'(len_q), bit_idx);
        drv_bit   = |(tx_q & (ONE << bit_pos(lsb_q, int'(len_q), drv_idx)));
        first_bit = |(spi_tx_data & (ONE << bit_pos(spi_cfg_lsb_first, int'(len_eff), 0)));
        csn_sel   = '1;
        for (int i = 0; i < CS_NUM; i++) begin
            csn_sel[i] = (spi_cfg_cs != CS_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_busy     <= 1'b0;
            spi_done     <= 1'b0;
            spi_rx_valid <= 1'b0;
            spi_rx_data  <= '0;
            spi_sck      <= 1'b0;
            spi_csn      <= '1;
            spi_mosi     <= 1'b0;
            mode_q       <= '0;
            lsb_q        <= 1'b0;
            div_q        <= '0;
            len_q        <= '0;
            tx_q         <= '0;
            rx_sh        <= '0;
            edge_q       <= '0;
        end else begin
            spi_done     <= 1'b0;
            spi_rx_valid <= 1'b0;
            if (accept) begin
                mode_q   <= '{cpol: spi_cfg_cpol, cpha: spi_cfg_cpha};
                lsb_q    <= spi_cfg_lsb_first;
                div_q    <= spi_cfg_div;
                len_q    <= len_eff;
                tx_q     <= spi_tx_data;
                rx_sh    <= '0;
                edge_q   <= '0;
                spi_busy <= 1'b1;
                spi_sck  <= spi_cfg_cpol;
                spi_csn  <= csn_sel;
                spi_mosi <= spi_cfg_cpha ? 1'b0 : first_bit;
            end else if (state == DONE) begin
                spi_busy <= 1'b0;
            end
            if (edge_go) begin
                spi_sck <= ~spi_sck;
                edge_q  <= edge_q + 1'b1;
                if (samp) begin
                    if (spi_miso) rx_sh <= rx_sh | (ONE << rx_pos);
                end else if (drv_ok) begin
                    spi_mosi <= drv_bit;
                end
            end
            if ((state == HOLD) && tick) begin
                spi_done     <= 1'b1;
                spi_rx_valid <= 1'b1;
                spi_rx_data  <= rx_sh;
                spi_csn      <= '1;
                spi_mosi     <= 1'b0;
                spi_sck      <= mode_q.cpol;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: vector table of whole frames plus hand-written
// sequences for mid-frame start, back-to-back start and mid-frame reset.
module tb_spi_master_cfg;

    // CS_NUM=3 leaves index 3 representable on the 2-bit cs field (out-of-range select).
    localparam int DW = 32;
    localparam int NCS = 3;

    logic        clk, rst_n, spi_start;
    logic        spi_cfg_cpol, spi_cfg_cpha, spi_cfg_lsb_first;
    logic [7:0]  spi_cfg_div;
    logic [5:0]  spi_cfg_len;
    logic [1:0]  spi_cfg_cs;
    logic [31:0] spi_tx_data, spi_rx_data;
    logic        spi_busy, spi_done, spi_rx_valid, spi_sck, spi_mosi, spi_miso;
    logic [2:0]  spi_csn;

    logic        loopback, slv_miso;
    logic        s_cpol, s_cpha, s_lsb, s_prev_cs, s_prev_sck, s_cs_now;
    logic [1:0]  s_cs;
    logic [31:0] s_tx, slv_rx;
    int          s_len, s_cnt;
    int          n_chk, n_fail;

    typedef struct {
        logic        cpol, cpha, lsb, slave;
        logic [7:0]  div;
        logic [5:0]  len;
        logic [1:0]  cs;
        logic [31:0] tx, slv_tx, exp_rx, exp_slv;
        int          exp_lat, exp_low;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];
    vec_t va, vb, vr;

    spi_master_cfg #(.DW(DW), .CS_NUM(NCS), .DIV_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .spi_start         (spi_start),
        .spi_cfg_cpol      (spi_cfg_cpol),
        .spi_cfg_cpha      (spi_cfg_cpha),
        .spi_cfg_lsb_first (spi_cfg_lsb_first),
        .spi_cfg_div       (spi_cfg_div),
        .spi_cfg_len       (spi_cfg_len),
        .spi_cfg_cs        (spi_cfg_cs),
        .spi_tx_data       (spi_tx_data),
        .spi_busy          (spi_busy),
        .spi_done          (spi_done),
        .spi_rx_data       (spi_rx_data),
        .spi_rx_valid      (spi_rx_valid),
        .spi_sck           (spi_sck),
        .spi_csn           (spi_csn),
        .spi_mosi          (spi_mosi),
        .spi_miso          (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign spi_miso = loopback ? spi_mosi : slv_miso;

    function automatic vec_t mk(input logic cpol, input logic cpha, input logic lsb, input logic [7:0] div,
                                input logic [5:0] len, input logic [1:0] cs, input logic [31:0] tx,
                                input logic slave, input logic [31:0] slv_tx, input logic [31:0] exp_rx,
                                input int exp_lat, input int exp_low, input logic [31:0] exp_slv);
        vec_t v;
        v.cpol = cpol; v.cpha = cpha; v.lsb = lsb; v.div = div; v.len = len; v.cs = cs; v.tx = tx;
        v.slave = slave; v.slv_tx = slv_tx; v.exp_rx = exp_rx; v.exp_lat = exp_lat;
        v.exp_low = exp_low; v.exp_slv = exp_slv;
        return v;
    endfunction

    function automatic int spos(input int c);
        return s_lsb ? c : (s_len - 1 - c);
    endfunction

    function automatic logic gbit(input logic [31:0] w, input int p);
        logic [31:0] t;
        t = w >> p;
        return t[0];
    endfunction

    // Independent SPI target: polls pins on the falling clk edge, mode-aware.
    always @(negedge clk) begin
        s_cs_now = (s_cs < 2'd3) ? spi_csn[s_cs] : 1'b1;
        if (s_prev_cs && !s_cs_now) begin
            s_cnt  = 0;
            slv_rx = '0;
            if (!s_cpha) slv_miso = gbit(s_tx, spos(0));
        end else if (!s_cs_now && (spi_sck != s_prev_sck)) begin
            if ((spi_sck != s_cpol) == !s_cpha) begin
                if (spi_mosi) slv_rx = slv_rx | (32'd1 << spos(s_cnt));
                if (s_cpha) s_cnt++;
            end else begin
                if (!s_cpha) s_cnt++;
                if (s_cnt < s_len) slv_miso = gbit(s_tx, spos(s_cnt));
            end
        end
        s_prev_cs  = s_cs_now;
        s_prev_sck = spi_sck;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic start_frame(input vec_t v);
        spi_cfg_cpol      = v.cpol;
        spi_cfg_cpha      = v.cpha;
        spi_cfg_lsb_first = v.lsb;
        spi_cfg_div       = v.div;
        spi_cfg_len       = v.len;
        spi_cfg_cs        = v.cs;
        spi_tx_data       = v.tx;
        loopback          = !v.slave;
        s_cpol = v.cpol; s_cpha = v.cpha; s_lsb = v.lsb; s_cs = v.cs; s_tx = v.slv_tx;
        s_len  = ((v.len == 6'd0) || (v.len > 6'd32)) ? 32 : int'(v.len);
        spi_start = 1'b1;
    endtask

    // Returns at the falling edge inside the done cycle; mid>0 injects a stray start.
    task automatic watch_frame(input vec_t v, input int mid, input string nm);
        int lat, low, bbad;
        logic first_ok, rxv, sck_d, mosi_d;
        logic [31:0] rx;
        logic [2:0] one, sel;
        lat = 0; low = 0; bbad = 0; first_ok = 1'b0; rxv = 1'b0; sck_d = 1'b0; mosi_d = 1'b1; rx = '0;
        one = 3'b001;
        sel = (v.cs < 2'd3) ? ~(one << v.cs) : 3'b111;
        for (int k = 1; (k <= 3000) && (lat == 0); k++) begin
            @(negedge clk);
            if (k == 1) spi_start = 1'b0;
            if ((mid != 0) && (k == mid)) begin
                spi_start = 1'b1; spi_cfg_len = 6'd4; spi_tx_data = 32'hFF; spi_cfg_cpha = 1'b1;
            end
            if ((mid != 0) && (k == mid + 1)) spi_start = 1'b0;
            if ((v.cs < 2'd3) ? (spi_csn == sel) : (spi_csn != 3'b111)) low++;
            if (k == 1) first_ok = (spi_csn == sel);
            if (!spi_busy) bbad++;
            if (spi_done) begin
                lat = k; rx = spi_rx_data; rxv = spi_rx_valid; sck_d = spi_sck; mosi_d = spi_mosi;
            end
        end
        chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, "_csn_low_cycles"}, 32'(low), 32'(v.exp_low));
        chk({nm, "_csn_first_cycle"}, {31'd0, first_ok}, 32'd1);
        chk({nm, "_rx_data"}, rx, v.exp_rx);
        chk({nm, "_rx_valid"}, {31'd0, rxv}, 32'd1);
        chk({nm, "_busy_gaps"}, 32'(bbad), 32'd0);
        chk({nm, "_sck_at_done"}, {31'd0, sck_d}, {31'd0, v.cpol});
        chk({nm, "_mosi_at_done"}, {31'd0, mosi_d}, 32'd0);
        if (v.slave) chk({nm, "_slave_rx"}, slv_rx, v.exp_slv);
    endtask

    task automatic after_frame(input vec_t v, input string nm);
        @(negedge clk);
        chk({nm, "_busy_after"}, {31'd0, spi_busy}, 32'd0);
        chk({nm, "_rxv_after"}, {31'd0, spi_rx_valid}, 32'd0);
        chk({nm, "_rx_hold"}, spi_rx_data, v.exp_rx);
        chk({nm, "_sck_idle"}, {31'd0, spi_sck}, {31'd0, v.cpol});
    endtask

    initial begin
        int nd;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; spi_start = 1'b0; loopback = 1'b1; slv_miso = 1'b0;
        spi_cfg_cpol = 0; spi_cfg_cpha = 0; spi_cfg_lsb_first = 0; spi_cfg_div = 0;
        spi_cfg_len = 0; spi_cfg_cs = 0; spi_tx_data = 0;
        s_cpol = 0; s_cpha = 0; s_lsb = 0; s_cs = 0; s_tx = 0; s_len = 8; s_cnt = 0;
        s_prev_cs = 1'b1; s_prev_sck = 1'b0; slv_rx = 0;

        //            cpol cpha lsb div  len    cs  tx            slv slv_tx  exp_rx        lat  low  exp_slv
        vecs[0]  = mk(0,   0,   0,  0,   6'd8,  0,  32'hA5,       0,  0,      32'hA5,       19,  18,  0);
        vecs[1]  = mk(1,   1,   1,  3,   6'd16, 2,  32'h1234,     1,  'hBEEF, 32'hBEEF,     137, 136, 32'h1234);
        vecs[2]  = mk(0,   1,   0,  1,   6'd5,  1,  32'h13,       0,  0,      32'h13,       25,  24,  0);
        vecs[3]  = mk(0,   0,   0,  0,   6'd0,  0,  32'hDEADBEEF, 0,  0,      32'hDEADBEEF, 67,  66,  0);
        vecs[4]  = mk(0,   1,   0,  0,   6'd0,  1,  32'hDEADBEEF, 0,  0,      32'hDEADBEEF, 67,  66,  0);
        vecs[5]  = mk(1,   0,   1,  0,   6'd0,  2,  32'hDEADBEEF, 0,  0,      32'hDEADBEEF, 67,  66,  0);
        vecs[6]  = mk(1,   1,   1,  0,   6'd0,  0,  32'hDEADBEEF, 0,  0,      32'hDEADBEEF, 67,  66,  0);
        vecs[7]  = mk(0,   0,   0,  0,   6'd40, 1,  32'hDEADBEEF, 0,  0,      32'hDEADBEEF, 67,  66,  0);
        vecs[8]  = mk(0,   0,   0,  1,   6'd4,  3,  32'h9,        0,  0,      32'h9,        21,  0,   0);
        vecs[9]  = mk(1,   0,   1,  2,   6'd1,  0,  32'hFFFFFFFF, 0,  0,      32'h1,        13,  12,  0);
        vecs[10] = mk(0,   0,   0,  2,   6'd8,  1,  32'hC3,       1,  'h3C,   32'h3C,       55,  54,  32'hC3);

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, spi_busy}, 32'd0);
        chk("rst_done", {31'd0, spi_done}, 32'd0);
        chk("rst_rx_valid", {31'd0, spi_rx_valid}, 32'd0);
        chk("rst_rx_data", spi_rx_data, 32'd0);
        chk("rst_sck", {31'd0, spi_sck}, 32'd0);
        chk("rst_csn", {29'd0, spi_csn}, 32'd7);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            repeat (2) @(negedge clk);
            start_frame(vecs[i]);
            watch_frame(vecs[i], 0, $sformatf("v%0d", i));
            after_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Stray start mid-frame: ignored, not queued.
        va = mk(0, 0, 0, 1, 6'd8, 0, 32'h5A, 0, 0, 32'h5A, 37, 36, 0);
        repeat (2) @(negedge clk);
        start_frame(va);
        watch_frame(va, 10, "midstart");
        nd = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (spi_done) nd++;
        end
        chk("midstart_extra_done", 32'(nd), 32'd0);
        chk("midstart_idle_busy", {31'd0, spi_busy}, 32'd0);

        // Start presented during the done cycle: next frame begins with no idle gap.
        vb = mk(0, 0, 0, 0, 6'd4, 1, 32'h6, 0, 0, 32'h6, 11, 10, 0);
        repeat (2) @(negedge clk);
        start_frame(vecs[0]);
        watch_frame(vecs[0], 0, "b2b_a");
        start_frame(vb);
        watch_frame(vb, 0, "b2b_b");
        after_frame(vb, "b2b_b");

        // Asynchronous reset in the middle of XFER.
        vr = mk(1, 1, 0, 1, 6'd8, 2, 32'h96, 0, 0, 32'h96, 37, 36, 0);
        repeat (2) @(negedge clk);
        start_frame(vr);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) spi_start = 1'b0;
        end
        chk("mrst_pre_sck", {31'd0, spi_sck}, 32'd1);
        chk("mrst_pre_csn", {29'd0, spi_csn}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mrst_csn", {29'd0, spi_csn}, 32'd7);
        chk("mrst_sck", {31'd0, spi_sck}, 32'd0);
        chk("mrst_busy", {31'd0, spi_busy}, 32'd0);
        chk("mrst_mosi", {31'd0, spi_mosi}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (spi_done || spi_rx_valid) nd++;
        end
        chk("mrst_no_done", 32'(nd), 32'd0);
        start_frame(vecs[0]);
        watch_frame(vecs[0], 0, "mrst_next");
        after_frame(vecs[0], "mrst_next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
